// File: rtl/tune_sequencer.sv
// Song-ROM driven square-wave tone sequencer with play/pause/stop, rests,
// per-note beat durations, an end-of-song marker and optional looping.
module tune_sequencer #(
  parameter int unsigned CLK_HZ    = 10000000,
  parameter int unsigned BEAT_HZ   = 4,
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned SONG_LEN  = 64,
  parameter int unsigned PER_BITS  = 16,
  parameter int unsigned DUR_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         pause,
  input  logic                         stop,
  input  logic                         loop_en,
  output logic [ADDR_BITS-1:0]         rom_addr,
  input  logic [PER_BITS+DUR_BITS-1:0] rom_data,
  output logic                         speaker,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned BEAT_DIV  = CLK_HZ / BEAT_HZ;
  localparam int unsigned BEAT_BITS = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BEAT_DIV - 1);
  localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(SONG_LEN - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  localparam logic [PER_BITS-1:0]  PER_ONE   = PER_BITS'(1);
  localparam logic [DUR_BITS-1:0]  DUR_ONE   = DUR_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_PAUSED
  } state_t;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_speaker;
  logic                 r_done;
  logic [PER_BITS-1:0]  r_note_per;
  logic [DUR_BITS-1:0]  r_note_dur;
  logic [PER_BITS-1:0]  r_tone_cnt;
  logic [BEAT_BITS-1:0] r_beat_cnt;
  logic [DUR_BITS-1:0]  r_beats_left;

  logic [PER_BITS-1:0]  w_rom_per;
  logic [DUR_BITS-1:0]  w_rom_dur;
  logic                 w_rest;
  logic                 w_tone_wrap;
  logic                 w_beat_wrap;
  logic                 w_note_end;
  logic                 w_song_end;

  assign w_rom_per   = rom_data[PER_BITS+DUR_BITS-1:DUR_BITS];
  assign w_rom_dur   = rom_data[DUR_BITS-1:0];
  assign w_rest      = (r_note_per == '0);
  assign w_tone_wrap = (r_tone_cnt == r_note_per - PER_ONE);
  assign w_beat_wrap = (r_beat_cnt == BEAT_LAST);
  assign w_note_end  = w_beat_wrap && ((r_beats_left + DUR_ONE) == r_note_dur);
  assign w_song_end  = (r_addr == ADDR_LAST);

  assign rom_addr = r_addr;
  assign speaker  = r_speaker;
  assign done     = r_done;
  assign busy     = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                    (r_state == S_PLAY)  || (r_state == S_PAUSED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_speaker    <= 1'b0;
      r_done       <= 1'b0;
      r_note_per   <= '0;
      r_note_dur   <= '0;
      r_tone_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_beats_left <= '0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state      <= S_IDLE;
        r_addr       <= '0;
        r_speaker    <= 1'b0;
        r_tone_cnt   <= '0;
        r_beat_cnt   <= '0;
        r_beats_left <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play && !pause) r_state <= S_FETCH;
          end
          S_FETCH: begin
            r_state <= S_LOAD;
          end
          S_LOAD: begin
            r_note_per   <= w_rom_per;
            r_note_dur   <= w_rom_dur;
            r_tone_cnt   <= '0;
            r_beat_cnt   <= '0;
            r_beats_left <= '0;
            r_speaker    <= 1'b0;
            // A zero duration word is the end-of-song marker
            if (w_rom_dur == '0) begin
              r_addr <= '0;
              if (loop_en) begin
                r_state <= S_FETCH;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_state <= S_PLAY;
            end
          end
          S_PLAY: begin
            // Every PLAY cycle is counted, including the one that sees pause,
            // so a note always spends dur*BEAT_DIV cycles in PLAY.
            if (w_rest) begin
              r_tone_cnt <= '0;
              r_speaker  <= 1'b0;
            end else if (w_tone_wrap) begin
              r_tone_cnt <= '0;
              r_speaker  <= ~r_speaker;
            end else begin
              r_tone_cnt <= r_tone_cnt + PER_ONE;
            end
            if (w_beat_wrap) begin
              r_beat_cnt   <= '0;
              r_beats_left <= r_beats_left + DUR_ONE;
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_ONE;
            end
            if (w_note_end) begin
              r_speaker <= 1'b0;
              if (w_song_end) begin
                r_addr <= '0;
                if (loop_en) begin
                  r_state <= S_FETCH;
                end else begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_addr  <= r_addr + ADDR_ONE;
                r_state <= S_FETCH;
              end
            end else if (pause) begin
              r_state <= S_PAUSED;
            end
          end
          S_PAUSED: begin
            if (!pause && play) r_state <= S_PLAY;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
